// File: rtl/cpu_multicycle.sv
// Multi-cycle FETCH/EXEC/MEM core for the team 8-bit ISA, parametrised in datapath,
// register-file and PC width. Drives registered data-memory requests with a BUSYWAIT handshake.
module cpu_multicycle #(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 3,
    parameter int PC_W       = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic [PC_W-1:0]   PC,
    input  logic [31:0]       INSTRUCTION,
    output logic              READ,
    output logic              WRITE,
    input  logic              BUSYWAIT,
    output logic [DATA_W-1:0] ADDRESS,
    output logic [DATA_W-1:0] WRITEDATA,
    input  logic [DATA_W-1:0] READDATA
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_LWD   = 8'h08;
    localparam logic [7:0] OP_LWI   = 8'h09;
    localparam logic [7:0] OP_SWD   = 8'h0A;
    localparam logic [7:0] OP_SWI   = 8'h0B;
    localparam logic [7:0] OP_BNE   = 8'h0C;
    localparam logic [7:0] OP_SLL   = 8'h0D;
    localparam logic [7:0] OP_SRL   = 8'h0E;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2
    } state_e;

    state_e              state_q;
    logic [PC_W-1:0]     pc_q;
    logic [31:0]         ir_q;
    logic                read_q;
    logic                write_q;
    logic [DATA_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rf_q [NUM_REGS];

    // Instruction fields, always decoded from the latched IR.
    logic [7:0]            op;
    logic [7:0]            imm8;
    logic [7:0]            off8;
    logic [REG_ADDR_W-1:0] dst_idx;
    logic [REG_ADDR_W-1:0] src1_idx;
    logic [REG_ADDR_W-1:0] src2_idx;
    logic                  unused_src1_hi;

    assign op       = ir_q[31:24];
    assign off8     = ir_q[23:16];
    assign imm8     = ir_q[7:0];
    assign dst_idx  = ir_q[16 +: REG_ADDR_W];
    assign src1_idx = ir_q[8 +: REG_ADDR_W];
    assign src2_idx = ir_q[0 +: REG_ADDR_W];
    assign unused_src1_hi = ^ir_q[15:8];

    logic [DATA_W-1:0] src1_val;
    logic [DATA_W-1:0] src2_val;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] diff;
    logic              zero;
    logic              shift_oob;

    // Reads see the register contents before this instruction's own writeback.
    assign src1_val  = rf_q[src1_idx];
    assign src2_val  = rf_q[src2_idx];
    assign imm_sext  = DATA_W'($signed(imm8));
    assign diff      = src1_val + (~src2_val) + DATA_W'(1);
    assign zero      = (diff == '0);
    assign shift_oob = (32'(imm8) >= DATA_W);

    logic [DATA_W-1:0] alu_res;
    logic              is_alu;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        alu_res = '0;
        is_alu  = 1'b1;
        case (op)
            OP_LOADI: alu_res = imm_sext;
            OP_MOV:   alu_res = src2_val;
            OP_ADD:   alu_res = src1_val + src2_val;
            OP_SUB:   alu_res = diff;
            OP_AND:   alu_res = src1_val & src2_val;
            OP_OR:    alu_res = src1_val | src2_val;
            OP_SLL:   alu_res = shift_oob ? '0 : (src1_val << imm8);
            OP_SRL:   alu_res = shift_oob ? '0 : (src1_val >> imm8);
            default:  is_alu  = 1'b0;
        endcase
    end

    logic              is_mem;
    logic              is_load;
    logic              take_branch;
    logic [DATA_W-1:0] mem_addr;
    logic [PC_W-1:0]   pc_plus4;
    logic [PC_W-1:0]   pc_target;

    assign is_mem      = (op >= OP_LWD) && (op <= OP_SWI);
    assign is_load     = (op == OP_LWD) || (op == OP_LWI);
    assign mem_addr    = ((op == OP_LWD) || (op == OP_SWD)) ? src2_val : imm_sext;
    assign take_branch = (op == OP_J) || ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);
    assign pc_plus4    = pc_q + PC_W'(4);
    assign pc_target   = pc_plus4 + (PC_W'($signed(off8)) << 2);

    // Single write port: ALU result in EXEC, load data on the completing MEM cycle.
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;

    assign rf_we    = ((state_q == S_EXEC) && is_alu)
                   || ((state_q == S_MEM) && is_load && !BUSYWAIT);
    assign rf_wdata = (state_q == S_MEM) ? READDATA : alu_res;

    // NOTE: the register file is cleared on reset, so it maps to flops rather than a RAM macro.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[dst_idx] <= rf_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    ir_q    <= INSTRUCTION;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_mem) begin
                        addr_q  <= mem_addr;
                        wdata_q <= src1_val;
                        read_q  <= is_load;
                        write_q <= !is_load;
                        state_q <= S_MEM;
                    end else begin
                        pc_q    <= take_branch ? pc_target : pc_plus4;
                        state_q <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (!BUSYWAIT) begin
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        pc_q    <= pc_plus4;
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign PC        = pc_q;
    assign READ      = read_q;
    assign WRITE     = write_q;
    assign ADDRESS   = addr_q;
    assign WRITEDATA = wdata_q;

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: an 8-bit core with a latency-programmable data memory,
// plus a 16-bit/16-register instance for the wide-datapath and jump-to-self cases.
module tb_cpu_multicycle;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 8-bit instance and its memories.
    logic        rst;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        rd, wr, busy;
    logic [7:0]  addr, wdata, rdata;
    logic [31:0] imem [64];
    logic [7:0]  dmem [256];
    logic        dmem_init = 1'b0;
    int          mem_lat   = 0;
    int          busy_cnt  = 0;
    int          both_hi   = 0;

    assign instr = imem[pc[7:2]];
    assign busy  = (rd | wr) && (busy_cnt < mem_lat);
    assign rdata = dmem[addr];

    always @(posedge clk) begin
        if (dmem_init) begin
            for (int i = 0; i < 256; i++) begin
                dmem[i] <= (i == 18) ? 8'h5A : (i == 48) ? 8'h77 : 8'hAA;
            end
        end else if (wr === 1'b1 && !busy) begin
            dmem[addr] <= wdata;
        end
        if (!(rd | wr)) busy_cnt <= 0;
        else if (busy) busy_cnt <= busy_cnt + 1;
    end

    cpu_multicycle dut (
        .CLK(clk), .RESET(rst), .PC(pc), .INSTRUCTION(instr),
        .READ(rd), .WRITE(wr), .BUSYWAIT(busy),
        .ADDRESS(addr), .WRITEDATA(wdata), .READDATA(rdata)
    );

    // 16-bit instance with an always-ready memory.
    logic        rst16;
    logic [31:0] pc16;
    logic [31:0] instr16;
    logic        rd16, wr16, busy16;
    logic [15:0] addr16, wdata16, rdata16;
    logic [31:0] imem16 [64];

    assign instr16 = imem16[pc16[7:2]];
    assign busy16  = 1'b0;
    assign rdata16 = 16'h0000;

    cpu_multicycle #(.DATA_W(16), .REG_ADDR_W(4), .PC_W(32)) dut16 (
        .CLK(clk), .RESET(rst16), .PC(pc16), .INSTRUCTION(instr16),
        .READ(rd16), .WRITE(wr16), .BUSYWAIT(busy16),
        .ADDRESS(addr16), .WRITEDATA(wdata16), .READDATA(rdata16)
    );

    always @(negedge clk) begin
        if ((rd === 1'b1 && wr === 1'b1) || (rd16 === 1'b1 && wr16 === 1'b1)) both_hi++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic [7:0] c);
        return {op, a, b, c};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) imem[i] = 32'hFF00_0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dmem_init = 1'b1;
        cycles(2);
        dmem_init = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        rst16 = 1'b1;
        for (int i = 0; i < 64; i++) imem16[i] = 32'hFF00_0000;
        imem16[0] = ins(8'h00, 8'd15, 8'd0, 8'hFF);   // loadi r15,-1
        imem16[1] = ins(8'h0B, 8'd0, 8'd15, 8'h80);   // swi r15,0x80
        imem16[2] = ins(8'h06, 8'hFF, 8'd0, 8'd0);    // j -1

        // Test 1: reset state and simple ALU sequence.
        clear_prog();
        imem[0] = ins(8'h00, 8'd1, 8'd0, 8'd5);       // loadi r1,5
        imem[1] = ins(8'h00, 8'd2, 8'd0, 8'd3);       // loadi r2,3
        imem[2] = ins(8'h02, 8'd3, 8'd1, 8'd2);       // add r3,r1,r2
        imem[3] = ins(8'h0B, 8'd0, 8'd3, 8'h00);      // swi r3,0x00
        dmem_init = 1'b1;
        cycles(2);
        dmem_init = 1'b0;
        check("rst_pc", pc, 32'd0);
        check("rst_read", {31'd0, rd}, 32'd0);
        check("rst_write", {31'd0, wr}, 32'd0);
        check("rst_address", {24'd0, addr}, 32'd0);
        check("rst_writedata", {24'd0, wdata}, 32'd0);
        check("rst16_pc", pc16, 32'd0);
        rst = 1'b0;
        cycles(6);
        check("t1_pc_after_add", pc, 32'd12);
        cycles(3);
        check("t1_pc_after_store", pc, 32'd16);
        check("t1_r3_sum", {24'd0, dmem[0]}, 32'h08);

        // Test 2: sub to zero, beq taken, bne not taken, bne taken, beq not taken.
        clear_prog();
        imem[0] = ins(8'h00, 8'd1, 8'd0, 8'h02);      // loadi r1,2
        imem[1] = ins(8'h03, 8'd4, 8'd1, 8'd1);       // sub r4,r1,r1
        imem[2] = ins(8'h07, 8'd2, 8'd1, 8'd1);       // beq +2,r1,r1
        imem[5] = ins(8'h0C, 8'd3, 8'd1, 8'd1);       // 0x14: bne +3,r1,r1
        imem[6] = ins(8'h0B, 8'd0, 8'd4, 8'h01);      // 0x18: swi r4,0x01
        imem[7] = ins(8'h0C, 8'd1, 8'd1, 8'd4);       // 0x1C: bne +1,r1,r4
        imem[9] = ins(8'h07, 8'd5, 8'd1, 8'd4);       // 0x24: beq +5,r1,r4
        do_reset();
        cycles(6);
        check("t2_beq_taken_pc", pc, 32'h14);
        cycles(2);
        check("t2_bne_not_taken_pc", pc, 32'h18);
        cycles(3);
        check("t2_pc_after_store", pc, 32'h1C);
        check("t2_r4_sub_zero", {24'd0, dmem[1]}, 32'h00);
        cycles(2);
        check("t2_bne_taken_pc", pc, 32'h24);
        cycles(2);
        check("t2_beq_not_taken_pc", pc, 32'h28);

        // Test 3: store with 3 busy cycles, loads (imm and register addressed), register store.
        clear_prog();
        imem[0] = ins(8'h00, 8'd1, 8'd0, 8'h02);      // loadi r1,2
        imem[1] = ins(8'h0B, 8'd0, 8'd1, 8'h10);      // swi r1,0x10
        imem[2] = ins(8'h09, 8'd5, 8'd0, 8'h10);      // lwi r5,0x10
        imem[3] = ins(8'h0B, 8'd0, 8'd5, 8'h11);      // swi r5,0x11
        imem[4] = ins(8'h00, 8'd2, 8'd0, 8'h12);      // loadi r2,0x12
        imem[5] = ins(8'h08, 8'd7, 8'd0, 8'd2);       // lwd r7,r2
        imem[6] = ins(8'h0A, 8'd0, 8'd7, 8'd1);       // swd r7,r1
        mem_lat = 3;
        do_reset();
        cycles(2);
        check("t3_pc_after_loadi", pc, 32'd4);
        cycles(2);
        check("t3_swi_write", {31'd0, wr}, 32'd1);
        check("t3_swi_read", {31'd0, rd}, 32'd0);
        n = 0;
        while (wr === 1'b1 && n < 20) begin
            check("t3_swi_hold_address", {24'd0, addr}, 32'h10);
            check("t3_swi_hold_writedata", {24'd0, wdata}, 32'h02);
            n++;
            cycles(1);
        end
        check("t3_write_mem_cycles", n, 32'd4);
        check("t3_pc_after_swi", pc, 32'd8);
        check("t3_dmem_10", {24'd0, dmem[8'h10]}, 32'h02);
        mem_lat = 1;
        cycles(2);
        check("t3_lwi_read", {31'd0, rd}, 32'd1);
        check("t3_lwi_address", {24'd0, addr}, 32'h10);
        cycles(2);
        check("t3_pc_after_lwi", pc, 32'd12);
        mem_lat = 0;
        cycles(3);
        check("t3_r5_loaded", {24'd0, dmem[8'h11]}, 32'h02);
        cycles(8);
        check("t3_pc_after_swd", pc, 32'd28);
        check("t3_lwd_swd", {24'd0, dmem[8'h02]}, 32'h5A);

        // Test 4: shifts, wrap-around add, and/or/sub/srl, unknown opcode as NOP.
        clear_prog();
        imem[0]  = ins(8'h00, 8'd1, 8'd0, 8'h02);     // loadi r1,2
        imem[1]  = ins(8'h0D, 8'd6, 8'd1, 8'd3);      // sll r6,r1,3
        imem[2]  = ins(8'h0B, 8'd0, 8'd6, 8'h20);     // swi r6,0x20
        imem[3]  = ins(8'h0E, 8'd6, 8'd6, 8'd9);      // srl r6,r6,9
        imem[4]  = ins(8'h0B, 8'd0, 8'd6, 8'h21);     // swi r6,0x21
        imem[5]  = ins(8'h00, 8'd2, 8'd0, 8'hFF);     // loadi r2,0xFF
        imem[6]  = ins(8'h00, 8'd3, 8'd0, 8'h01);     // loadi r3,1
        imem[7]  = ins(8'h02, 8'd4, 8'd2, 8'd3);      // add r4,r2,r3
        imem[8]  = ins(8'h0B, 8'd0, 8'd4, 8'h22);     // swi r4,0x22
        imem[9]  = ins(8'h00, 8'd5, 8'd0, 8'h3C);     // loadi r5,0x3C
        imem[10] = ins(8'h00, 8'd7, 8'd0, 8'h0F);     // loadi r7,0x0F
        imem[11] = ins(8'h04, 8'd6, 8'd5, 8'd7);      // and r6,r5,r7
        imem[12] = ins(8'h05, 8'd4, 8'd5, 8'd7);      // or r4,r5,r7
        imem[13] = ins(8'h03, 8'd3, 8'd1, 8'd7);      // sub r3,r1,r7
        imem[14] = ins(8'h0E, 8'd2, 8'd5, 8'd2);      // srl r2,r5,2
        imem[15] = ins(8'h0B, 8'd0, 8'd6, 8'h23);     // swi r6,0x23
        imem[16] = ins(8'h0B, 8'd0, 8'd4, 8'h24);     // swi r4,0x24
        imem[17] = ins(8'h0B, 8'd0, 8'd3, 8'h25);     // swi r3,0x25
        imem[18] = ins(8'h0B, 8'd0, 8'd2, 8'h26);     // swi r2,0x26
        imem[19] = ins(8'h55, 8'd1, 8'd1, 8'd1);      // undefined opcode
        do_reset();
        cycles(47);
        check("t4_pc_end", pc, 32'd80);
        check("t4_sll", {24'd0, dmem[8'h20]}, 32'h10);
        check("t4_srl_oversize", {24'd0, dmem[8'h21]}, 32'h00);
        check("t4_add_wrap", {24'd0, dmem[8'h22]}, 32'h00);
        check("t4_and", {24'd0, dmem[8'h23]}, 32'h0C);
        check("t4_or", {24'd0, dmem[8'h24]}, 32'h3F);
        check("t4_sub_neg", {24'd0, dmem[8'h25]}, 32'hF3);
        check("t4_srl", {24'd0, dmem[8'h26]}, 32'h0F);

        // Test 5: reset on the completing MEM cycle of lwd suppresses the writeback.
        clear_prog();
        imem[0] = ins(8'h00, 8'd2, 8'd0, 8'h30);      // loadi r2,0x30
        imem[1] = ins(8'h08, 8'd3, 8'd0, 8'd2);       // lwd r3,r2
        mem_lat = 1;
        do_reset();
        cycles(4);
        check("t5_lwd_read_first", {31'd0, rd}, 32'd1);
        cycles(1);
        check("t5_lwd_read_second", {31'd0, rd}, 32'd1);
        check("t5_busy_released", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        cycles(1);
        check("t5_read_dropped", {31'd0, rd}, 32'd0);
        check("t5_pc_reset", pc, 32'd0);
        clear_prog();
        imem[0] = ins(8'h0B, 8'd0, 8'd3, 8'h31);      // swi r3,0x31
        imem[1] = ins(8'h0B, 8'd0, 8'd2, 8'h32);      // swi r2,0x32
        mem_lat = 0;
        cycles(1);
        rst = 1'b0;
        cycles(3);
        check("t5_pc_after_store", pc, 32'd4);
        check("t5_r3_not_loaded", {24'd0, dmem[8'h31]}, 32'h00);
        cycles(3);
        check("t5_r2_cleared", {24'd0, dmem[8'h32]}, 32'h00);

        // Test 6: 16-bit datapath, 16 registers, jump to self.
        rst16 = 1'b0;
        cycles(2);
        check("t6_pc_after_loadi", pc16, 32'd4);
        cycles(2);
        check("t6_write", {31'd0, wr16}, 32'd1);
        check("t6_r15_all_ones", {16'd0, wdata16}, 32'h0000_FFFF);
        check("t6_address_sext", {16'd0, addr16}, 32'h0000_FF80);
        cycles(1);
        check("t6_pc_after_swi", pc16, 32'd8);
        cycles(2);
        check("t6_jump_self", pc16, 32'd8);
        cycles(4);
        check("t6_jump_self_again", pc16, 32'd8);

        check("read_write_exclusive", both_hi, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
